// File: rtl/enemy_draw_sequencer.sv
// Frame sequencer for the enemy sprite datapath: erase old sprites, load new coordinates, redraw.
// Optional frame divider is compiled in with ENEMY_SEQ_FRAME_DIV_EN.
module enemy_draw_sequencer #(
    parameter int NUM_SPRITES    = 10,
    parameter int PIX_PER_SPRITE = 25
`ifdef ENEMY_SEQ_FRAME_DIV_EN
    , parameter int FRAME_DIV    = 4
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       go,
    input  logic       halt,
    output logic       load_coord,
    output logic       enable,
    output logic [1:0] op,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic [2:0] dbg_state
);
    localparam int TOTAL = NUM_SPRITES * PIX_PER_SPRITE;
    localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_LOAD, S_DRAW, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_pass_q, first_pass_d;
    logic          load_q, load_d, enable_q, enable_d, plot_q, plot_d;
    logic [1:0]    op_q, op_d;
    logic          busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
    logic          accept, start, run;

    assign accept = (state_q == S_IDLE) && frame_tick && go && !halt;

`ifdef ENEMY_SEQ_FRAME_DIV_EN
    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (accept) begin
            div_d = (div_q == DW'(FRAME_DIV - 1)) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

    assign start = accept && (div_q == '0);
`else
    assign start = accept;
`endif

    // The counter advances only on cycles where enable was actually presented,
    // so the datapath sees exactly TOTAL advances per phase regardless of halts.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        first_pass_d = first_pass_q;
        case (state_q)
            S_IDLE:  if (start) state_d = first_pass_q ? S_LOAD : S_ERASE;
            S_ERASE: if (enable_q) begin
                         if (cnt_q == CW'(TOTAL - 1)) begin
                             cnt_d   = '0;
                             state_d = S_LOAD;
                         end else begin
                             cnt_d = cnt_q + 1'b1;
                         end
                     end
            S_LOAD:  begin
                         first_pass_d = 1'b0;
                         state_d      = S_DRAW;
                     end
            S_DRAW:  if (enable_q) begin
                         if (cnt_q == CW'(TOTAL - 1)) begin
                             cnt_d   = '0;
                             state_d = S_DONE;
                         end else begin
                             cnt_d = cnt_q + 1'b1;
                         end
                     end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run       = ((state_d == S_ERASE) || (state_d == S_DRAW)) && !halt;
        load_d    = (state_d == S_LOAD);
        enable_d  = run;
        plot_d    = run;
        op_d      = (state_d == S_ERASE) ? 2'b01 : 2'b00;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        overrun_d = frame_tick && (state_q != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            first_pass_q <= 1'b1;
            load_q       <= 1'b0;
            enable_q     <= 1'b0;
            plot_q       <= 1'b0;
            op_q         <= 2'b00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            first_pass_q <= first_pass_d;
            load_q       <= load_d;
            enable_q     <= enable_d;
            plot_q       <= plot_d;
            op_q         <= op_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign load_coord = load_q;
    assign enable     = enable_q;
    assign plot       = plot_q;
    assign op         = op_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_enemy_draw_sequencer.sv
// Directed bench for enemy_draw_sequencer: pass timing, halt, overrun, async reset, frame divider.
module tb_enemy_draw_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       go = 1'b0;
    logic       halt = 1'b0;
    logic       load_coord, enable, plot, busy, done, overrun;
    logic [1:0] op;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int tb_div = 0;

    int n_plot, n_erase, n_draw, n_op01, n_load, n_done, n_ovr, n_bad;
    int first_erase, last_erase, first_draw, last_draw;
    int load_cyc, done_cyc, ovr_cyc, idle_cyc;
    logic en_tr [0:1023];

    enemy_draw_sequencer dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .go(go), .halt(halt),
        .load_coord(load_coord), .enable(enable), .op(op), .plot(plot),
        .busy(busy), .done(done), .overrun(overrun), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        frame_tick = 1'b0;
        halt = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tb_div = 0;
    endtask

    // A tick in IDLE that the divider should swallow without starting a pass.
    task automatic idle_tick();
        @(posedge clk); #1;
        go = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check_val("divided_tick_busy", busy, 0);
        tb_div = (tb_div + 1) % 4;
    endtask

    task automatic align_divider();
`ifdef ENEMY_SEQ_FRAME_DIV_EN
        while (tb_div != 0) idle_tick();
`endif
    endtask

    task automatic run_pass(input int halt_at, input int halt_len, input int tick_at, input int max_cyc);
        align_divider();
        n_plot = 0; n_erase = 0; n_draw = 0; n_op01 = 0; n_load = 0; n_done = 0;
        n_ovr = 0; n_bad = 0; first_erase = -1; last_erase = -1; first_draw = -1;
        last_draw = -1; load_cyc = -1; done_cyc = -1; ovr_cyc = -1; idle_cyc = -1;
        for (int i = 0; i < 1024; i++) en_tr[i] = 1'b0;
        @(posedge clk); #1;
        go = 1'b1;
        halt = 1'b0;
        frame_tick = 1'b1;
`ifdef ENEMY_SEQ_FRAME_DIV_EN
        tb_div = (tb_div + 1) % 4;
`endif
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk); #1;
            frame_tick = (k == tick_at);
            halt = (k >= halt_at) && (k < halt_at + halt_len);
            en_tr[k] = enable;
            if (plot) n_plot++;
            if (plot && op == 2'b01) begin
                n_erase++;
                if (first_erase < 0) first_erase = k;
                last_erase = k;
            end
            if (plot && op == 2'b00) begin
                n_draw++;
                if (first_draw < 0) first_draw = k;
                last_draw = k;
            end
            if (op == 2'b01) n_op01++;
            if (load_coord) begin n_load++; if (load_cyc < 0) load_cyc = k; end
            if (done) begin n_done++; if (done_cyc < 0) done_cyc = k; end
            if (overrun) begin n_ovr++; if (ovr_cyc < 0) ovr_cyc = k; end
            if (enable != plot || op[1] || (load_coord && enable)) n_bad++;
            if (!busy) begin
                idle_cyc = k;
                break;
            end
        end
        frame_tick = 1'b0;
        halt = 1'b0;
    endtask

    initial begin
        int n_busy;
        int exp_start;
        int ovr_seen;
        do_reset();

        // Reset state
        @(posedge clk); #1;
        check_val("rst_load", load_coord, 0);
        check_val("rst_enable", enable, 0);
        check_val("rst_plot", plot, 0);
        check_val("rst_op", op, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_state", dbg_state, 0);

        // First pass skips erase
        run_pass(0, 0, 0, 600);
        check_val("p1_erase_pix", n_erase, 0);
        check_val("p1_load_cyc", load_cyc, 1);
        check_val("p1_first_draw", first_draw, 2);
        check_val("p1_last_draw", last_draw, 251);
        check_val("p1_draw_pix", n_draw, 250);
        check_val("p1_done_cyc", done_cyc, 252);
        check_val("p1_idle_cyc", idle_cyc, 253);
        check_val("p1_bad_outputs", n_bad, 0);

        // Normal erase/load/draw pass
        run_pass(0, 0, 0, 600);
        check_val("p2_first_erase", first_erase, 1);
        check_val("p2_last_erase", last_erase, 250);
        check_val("p2_erase_pix", n_erase, 250);
        check_val("p2_load_cyc", load_cyc, 251);
        check_val("p2_load_cnt", n_load, 1);
        check_val("p2_first_draw", first_draw, 252);
        check_val("p2_last_draw", last_draw, 501);
        check_val("p2_plot_total", n_plot, 500);
        check_val("p2_done_cyc", done_cyc, 502);
        check_val("p2_done_cnt", n_done, 1);
        check_val("p2_idle_cyc", idle_cyc, 503);
        check_val("p2_bad_outputs", n_bad, 0);

        // Ten-cycle halt in the middle of erase
        run_pass(101, 10, 0, 700);
        check_val("halt_en_before", en_tr[101], 1);
        check_val("halt_en_first_gap", en_tr[102], 0);
        check_val("halt_en_last_gap", en_tr[111], 0);
        check_val("halt_en_resume", en_tr[112], 1);
        check_val("halt_erase_pix", n_erase, 250);
        check_val("halt_op_hold", n_op01, 260);
        check_val("halt_last_erase", last_erase, 260);
        check_val("halt_load_cyc", load_cyc, 261);
        check_val("halt_draw_pix", n_draw, 250);
        check_val("halt_done_cyc", done_cyc, 512);
        check_val("halt_bad_outputs", n_bad, 0);

        // Tick mid-pass raises overrun and starts nothing
        run_pass(0, 0, 300, 600);
        check_val("ovr_cyc", ovr_cyc, 301);
        check_val("ovr_cnt", n_ovr, 1);
        check_val("ovr_done_cyc", done_cyc, 502);
        check_val("ovr_plot_total", n_plot, 500);
        n_busy = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy) n_busy++;
        end
        check_val("ovr_no_new_pass", n_busy, 0);

        // Tick in the DONE cycle is an overrun too
        run_pass(0, 0, 502, 600);
        check_val("ovr_done_tick_cyc", ovr_cyc, 503);
        check_val("ovr_done_tick_cnt", n_ovr, 1);
        check_val("ovr_done_tick_idle", idle_cyc, 503);

        // Asynchronous reset during draw
        align_divider();
        @(posedge clk); #1;
        go = 1'b1;
        frame_tick = 1'b1;
`ifdef ENEMY_SEQ_FRAME_DIV_EN
        tb_div = (tb_div + 1) % 4;
`endif
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        check_val("mid_draw_enable", enable, 1);
        check_val("mid_draw_op", op, 0);
        #3 reset = 1'b1;
        #1;
        check_val("arst_enable", enable, 0);
        check_val("arst_plot", plot, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_state", dbg_state, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tb_div = 0;
        run_pass(0, 0, 0, 600);
        check_val("arst_first_erase_pix", n_erase, 0);
        check_val("arst_first_load", load_cyc, 1);
        check_val("arst_first_done", done_cyc, 252);

        // Eight idle ticks from reset
        do_reset();
        ovr_seen = 0;
        for (int t = 0; t < 8; t++) begin
`ifdef ENEMY_SEQ_FRAME_DIV_EN
            exp_start = (t == 0 || t == 4) ? 1 : 0;
`else
            exp_start = 1;
`endif
            @(posedge clk); #1;
            go = 1'b1;
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            check_val($sformatf("tick%0d_start", t + 1), busy, exp_start);
            for (int k = 0; k < 600 && busy; k++) begin
                if (overrun) ovr_seen++;
                @(posedge clk); #1;
            end
            if (overrun) ovr_seen++;
            check_val($sformatf("tick%0d_idle", t + 1), busy, 0);
        end
        check_val("ticks_overrun", ovr_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end
endmodule
